// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM; define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  state_t r_state, w_next;
  logic [1:0] w_alu_op;
  logic w_pc_write, w_mem_write, w_ir_write, w_reg_write;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t BAD = TRAP;
  logic r_illegal;
  always_ff @(posedge clk)
    r_illegal <= ~reset & (r_illegal | (w_next == TRAP));
  assign Illegal = r_illegal;
`else
  localparam state_t BAD = FETCH;
  assign Illegal = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= reset ? FETCH : w_next;
  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = 2'b00;
    case (r_state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_ir_write = MemReady;
        w_pc_write = MemReady;
        w_next     = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_R ? EXECR :
                  op == OP_I ? EXECI :
                  op == OP_B ? BEQ :
                  op == OP_J ? JAL : BAD;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = MemReady ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
        w_next   = ALUWB;
      end
      EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
        w_next   = ALUWB;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
        w_next     = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        w_alu_op   = 2'b01;
        w_pc_write = Zero;
        w_next     = FETCH;
      end
      default: ;
    endcase
  end
  assign PCWrite  = w_pc_write & ~reset;
  assign IRWrite  = w_ir_write & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign ImmSrc = op == OP_SW ? 2'b01 : op == OP_B ? 2'b10 : op == OP_J ? 2'b11 : 2'b00;
  assign ALUControl = w_alu_op == 2'b00 ? 3'b000 :
                      w_alu_op == 2'b01 ? 3'b001 :
                      funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : 3'b000;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed checks of the multicycle control FSM outputs per state
module tb_mc_controller;
  logic clk = 1'b0, reset, funct7b5, Zero, MemReady;
  logic [6:0] op;
  logic [2:0] funct3;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  int n_run = 0, n_fail = 0;
  logic [13:0] obs;
  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal)
  );
  always #5 clk = ~clk;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUControl};
  localparam logic [13:0] S_FETCH  = {4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] S_FWAIT  = {4'b0000, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] S_DEC    = {4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 3'b000};
  localparam logic [13:0] S_MADR   = {4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000};
  localparam logic [13:0] S_MREAD  = {4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
  localparam logic [13:0] S_MWB    = {4'b0000, 2'b01, 2'b00, 2'b00, 1'b1, 3'b000};
  localparam logic [13:0] S_MWRITE = {4'b0110, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
  localparam logic [13:0] S_ALUWB  = {4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
  localparam logic [13:0] S_JAL    = {4'b1000, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000};
  localparam logic [13:0] S_BEQT   = {4'b1000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};
  localparam logic [13:0] S_BEQN   = {4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};
  localparam logic [13:0] S_ZERO   = 14'd0;
  function automatic logic [13:0] execr(input logic [2:0] ac);
    return {4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, ac};
  endfunction
  function automatic logic [13:0] execi(input logic [2:0] ac);
    return {4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, ac};
  endfunction
  task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic cyc(input string tag, input logic [13:0] e);
    #1;
    chk(tag, obs, e);
    @(posedge clk);
    #2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; MemReady = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #2;
    chk("rst_we_a", {10'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 14'd0);
    @(posedge clk); #2;
    chk("rst_we_b", {10'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 14'd0);
    chk("rst_illegal", {13'd0, Illegal}, 14'd0);
    reset = 1'b0;
    op = 7'b0000011;
    cyc("lw_fetch", S_FETCH);
    chk("lw_imm", {12'd0, ImmSrc}, 14'd0);
    cyc("lw_dec", S_DEC);
    cyc("lw_madr", S_MADR);
    cyc("lw_mread", S_MREAD);
    cyc("lw_mwb", S_MWB);
    MemReady = 1'b0;
    cyc("fetch_stall", S_FWAIT);
    MemReady = 1'b1;
    op = 7'b0100011;
    cyc("sw_fetch", S_FETCH);
    chk("sw_imm", {12'd0, ImmSrc}, 14'd1);
    cyc("sw_dec", S_DEC);
    cyc("sw_madr", S_MADR);
    MemReady = 1'b0;
    cyc("sw_mw0", S_MWRITE);
    cyc("sw_mw1", S_MWRITE);
    cyc("sw_mw2", S_MWRITE);
    MemReady = 1'b1;
    cyc("sw_mw3", S_MWRITE);
    op = 7'b1100011; Zero = 1'b1;
    cyc("sw_done_fetch", S_FETCH);
    chk("beq_imm", {12'd0, ImmSrc}, 14'd2);
    cyc("beqt_dec", S_DEC);
    cyc("beqt_beq", S_BEQT);
    Zero = 1'b0;
    cyc("beqn_fetch", S_FETCH);
    cyc("beqn_dec", S_DEC);
    cyc("beqn_beq", S_BEQN);
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc("sub_fetch", S_FETCH);
    cyc("sub_dec", S_DEC);
    cyc("sub_exec", execr(3'b001));
    cyc("sub_wb", S_ALUWB);
    op = 7'b0010011;
    cyc("addi_fetch", S_FETCH);
    cyc("addi_dec", S_DEC);
    cyc("addi_exec", execi(3'b000));
    cyc("addi_wb", S_ALUWB);
    op = 7'b0110011; funct7b5 = 1'b0; funct3 = 3'b111;
    cyc("and_fetch", S_FETCH);
    cyc("and_dec", S_DEC);
    cyc("and_exec", execr(3'b010));
    cyc("and_wb", S_ALUWB);
    funct3 = 3'b110;
    cyc("or_fetch", S_FETCH);
    cyc("or_dec", S_DEC);
    cyc("or_exec", execr(3'b011));
    cyc("or_wb", S_ALUWB);
    funct3 = 3'b010;
    cyc("slt_fetch", S_FETCH);
    cyc("slt_dec", S_DEC);
    cyc("slt_exec", execr(3'b101));
    cyc("slt_wb", S_ALUWB);
    op = 7'b1101111; funct3 = 3'b000;
    cyc("jal_fetch", S_FETCH);
    chk("jal_imm", {12'd0, ImmSrc}, 14'd3);
    cyc("jal_dec", S_DEC);
    cyc("jal_jal", S_JAL);
    cyc("jal_wb", S_ALUWB);
    op = 7'b0100011;
    cyc("mid_fetch", S_FETCH);
    cyc("mid_dec", S_DEC);
    cyc("mid_madr", S_MADR);
    MemReady = 1'b0;
    cyc("mid_mw", S_MWRITE);
    reset = 1'b1;
    #1;
    chk("mid_rst_mw", {13'd0, MemWrite}, 14'd0);
    @(posedge clk); #2;
    reset = 1'b0; MemReady = 1'b1;
    op = 7'b0000000;
    cyc("mid_refetch", S_FETCH);
    cyc("ill_dec", S_DEC);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("ill_flag_a", {13'd0, Illegal}, 14'd1);
    cyc("trap_a", S_ZERO);
    chk("ill_flag_b", {13'd0, Illegal}, 14'd1);
    op = 7'b0110011;
    cyc("trap_b", S_ZERO);
    chk("ill_flag_c", {13'd0, Illegal}, 14'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("ill_clear", {13'd0, Illegal}, 14'd0);
    cyc("trap_exit_fetch", S_FETCH);
`else
    chk("ill_flag", {13'd0, Illegal}, 14'd0);
    op = 7'b0110011;
    cyc("ill_nop_fetch", S_FETCH);
    chk("ill_flag_b", {13'd0, Illegal}, 14'd0);
    cyc("ill_next_dec", S_DEC);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
